// File: rtl/parity_frame_serializer_pkg.sv
// Shared encodings for the parity frame serializer: FSM states, line levels,
// and a width helper for counters that must be at least one bit wide.
package parity_frame_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_STOP  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // $clog2 of 1 is 0, which would give a zero-width counter.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_frame_serializer_even_parity.sv
// Even parity generator: output is 1 when the word holds an odd number of ones,
// so that word plus parity bit always carries an even count.
module even_parity_generator #(
  parameter int width = 8
) (
  input  logic [width-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_frame_serializer.sv
// Serial frame transmitter: start bit, data LSB first, optional parity, stop bit,
// each held for divisor clocks, fed one word at a time over valid/ready.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | line high, ready for a word
// ST_START  | line low for one bit time
// ST_DATA   | shift register bit 0 on the line, width bits
// ST_PARITY | latched parity bit on the line
// ST_STOP   | line high for one bit time, then back to idle
module parity_frame_serializer
  import parity_frame_serializer_pkg::*;
#(
  parameter int width   = 8,
  parameter int divisor = 16,
  parameter bit odd     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic [width-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_parity_en,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int CNT_W = clog2_min1(divisor);
  localparam int IDX_W = clog2_min1(width);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(divisor - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(width - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [width-1:0]   shift_q, shift_d;
  logic [width-1:0]   data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               tx_q, tx_d;
  logic               bit_last;
  logic               parity_even;
  logic               parity_bit;

  // Parity comes from an unshifted copy so it is stable for the parity slot.
  even_parity_generator #(
    .width (width)
  ) u_parity (
    .data   (data_q),
    .parity (parity_even)
  );

  assign parity_bit = parity_even ^ odd;
  assign bit_last   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      tx_q     <= LINE_IDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    par_en_d = par_en_q;

    if (state_q != ST_IDLE && !bit_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d  = ST_START;
          shift_d  = i_data;
          data_d   = i_data;
          par_en_d = i_parity_en;
          idx_d    = '0;
        end
      end
      ST_START: begin
        if (bit_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the next state so o_tx never glitches.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_d)
      ST_START:  tx_d = LINE_START;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_bit;
      ST_STOP:   tx_d = LINE_STOP;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = ~o_ready;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench: three serializer configurations sharing one clock and reset,
// frames compared clock by clock against hand-written bit sequences.
module tb_parity_frame_serializer;

  logic       clk = 1'b0;
  logic       rst_x;
  logic [7:0] i_data;
  logic       i_parity_en;
  logic [2:0] valid;

  logic tx_a, rdy_a, busy_a;
  logic tx_b, rdy_b, busy_b;
  logic tx_c, rdy_c, busy_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_frame_serializer #(.width(8), .divisor(4), .odd(1'b0)) u_dut_a (
    .clk(clk), .rst_x(rst_x), .i_data(i_data), .i_valid(valid[0]),
    .o_ready(rdy_a), .i_parity_en(i_parity_en), .o_tx(tx_a), .o_busy(busy_a)
  );

  parity_frame_serializer #(.width(8), .divisor(4), .odd(1'b1)) u_dut_b (
    .clk(clk), .rst_x(rst_x), .i_data(i_data), .i_valid(valid[1]),
    .o_ready(rdy_b), .i_parity_en(i_parity_en), .o_tx(tx_b), .o_busy(busy_b)
  );

  parity_frame_serializer #(.width(1), .divisor(1), .odd(1'b0)) u_dut_c (
    .clk(clk), .rst_x(rst_x), .i_data(i_data[0:0]), .i_valid(valid[2]),
    .o_ready(rdy_c), .i_parity_en(i_parity_en), .o_tx(tx_c), .o_busy(busy_c)
  );

  function automatic logic tx_s(input int s);
    return (s == 0) ? tx_a : (s == 1) ? tx_b : tx_c;
  endfunction

  function automatic logic rdy_s(input int s);
    return (s == 0) ? rdy_a : (s == 1) ? rdy_b : rdy_c;
  endfunction

  function automatic logic busy_s(input int s);
    return (s == 0) ? busy_a : (s == 1) ? busy_b : busy_c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns at the negedge of the cycle after the accept edge. Inputs are
  // scrambled right after accept to show they are ignored mid-frame.
  task automatic send(input int sel, input logic [7:0] d, input logic pe);
    int n = 0;
    @(negedge clk);
    while (!rdy_s(sel) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", rdy_s(sel), 1'b1);
    i_data      = d;
    i_parity_en = pe;
    valid[sel]  = 1'b1;
    @(negedge clk);
    valid[sel]  = 1'b0;
    i_data      = ~d;
    i_parity_en = ~pe;
  endtask

  // exp[i] is the i-th bit on the line (bit 0 = start bit).
  task automatic check_frame(input string tag, input int sel, input logic [10:0] exp,
                             input int nbits, input int div);
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < div; j++) begin
        check($sformatf("%s_bit%0d", tag, i), tx_s(sel), exp[i]);
        check($sformatf("%s_busy%0d", tag, i), busy_s(sel), 1'b1);
        @(negedge clk);
      end
    end
    check({tag, "_end_tx"}, tx_s(sel), 1'b1);
    check({tag, "_end_ready"}, rdy_s(sel), 1'b1);
    check({tag, "_end_busy"}, busy_s(sel), 1'b0);
  endtask

  initial begin
    logic [7:0] words [3];
    int k;
    int acc_prev;
    int n;

    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;

    // Reset with valid held high on A: must not be accepted until release.
    rst_x       = 1'b0;
    valid       = 3'b001;
    i_data      = 8'h55;
    i_parity_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_ready_a", rdy_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_tx_c", tx_c, 1'b1);
    rst_x = 1'b1;
    @(negedge clk);
    valid       = 3'b000;
    i_data      = 8'hAA;
    i_parity_en = 1'b0;

    // 0x55, even parity 0: 44 clocks, ready back at accept+45
    check_frame("t1_55", 0, 11'b1_0_01010101_0, 11, 4);

    // odd parity: 0x07 -> 0, 0x03 -> 1
    send(1, 8'h07, 1'b1);
    check_frame("t2_07", 1, 11'b1_0_00000111_0, 11, 4);
    send(1, 8'h03, 1'b1);
    check_frame("t2_03", 1, 11'b1_1_00000011_0, 11, 4);

    // parity off: 10-bit frame; parity_en is flipped on after accept
    send(0, 8'hA0, 1'b0);
    check_frame("t3_a0", 0, 11'b0_1_10100000_0, 10, 4);

    // valid held high, three words: accepts 45 clocks apart, 1 idle clock between
    i_data      = words[0];
    i_parity_en = 1'b1;
    valid[0]    = 1'b1;
    k           = 0;
    acc_prev    = 0;
    for (int c = 0; c < 300 && k < 3; c++) begin
      @(negedge clk);
      if (rdy_a) begin
        check("t4_idle_tx", tx_a, 1'b1);
        if (k > 0) check("t4_gap", c - acc_prev, 45);
        acc_prev = c;
        k++;
        @(negedge clk);
        c++;
        check("t4_start_tx", tx_a, 1'b0);
        if (k < 3) i_data = words[k];
      end
    end
    valid[0] = 1'b0;
    check("t4_accepts", k, 3);
    n = 0;
    while (!rdy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_drain", rdy_a, 1'b1);

    // reset during data bit 3 of 0xF0 (bit 3 is 0)
    send(0, 8'hF0, 1'b1);
    repeat (17) @(negedge clk);
    check("t5_bit3_tx", tx_a, 1'b0);
    check("t5_bit3_busy", busy_a, 1'b1);
    rst_x = 1'b0;
    @(negedge clk);
    check("t5_rst_tx", tx_a, 1'b1);
    check("t5_rst_ready", rdy_a, 1'b1);
    check("t5_rst_busy", busy_a, 1'b0);
    rst_x = 1'b1;
    send(0, 8'h3C, 1'b1);
    check_frame("t5_3c", 0, 11'b1_0_00111100_0, 11, 4);

    // width 1, divisor 1: 0,1,1,1
    send(2, 8'h01, 1'b1);
    check_frame("t6_w1", 2, 11'b0000000_1_1_1_0, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
